// File: rtl/act_skew_feeder_pkg.sv
// Shared definitions for the activation skew feeder: lane geometry and FSM encoding.
package act_skew_feeder_pkg;

    localparam int LANES  = 3;
    localparam int DATA_W = 8;
    localparam int ROW_W  = LANES * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/act_skew_feeder_row_buf.sv
// Activation row buffer: DEPTH x ROW_W register file, one write port and one
// combinational read port per lane, each returning that lane's byte of its row.
module act_row_buf
    import act_skew_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                          clk,
    input  logic                          i_we,
    input  logic [AW-1:0]                 i_waddr,
    input  logic [ROW_W-1:0]              i_wdata,
    input  logic [LANES-1:0][AW-1:0]      i_raddr,
    output logic [LANES-1:0][DATA_W-1:0]  o_rdata
);

    logic [ROW_W-1:0] r_mem [DEPTH];

    // NOTE: storage has no reset; reads are always qualified by the current
    // tile's row count, so stale rows from earlier tiles never reach a lane.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            o_rdata[k] = r_mem[i_raddr[k]][k*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/act_skew_feeder.sv
// Buffers one tile of activation rows, then streams them diagonally skewed
// into a 3x3 PE array, followed by a zero flush and a one-cycle done pulse.
module act_skew_feeder
    import act_skew_feeder_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int FLUSH = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ROW_W-1:0]  s_data,
    input  logic              s_last,
    output logic [DATA_W-1:0] in1,
    output logic [DATA_W-1:0] in2,
    output logic [DATA_W-1:0] in3,
    output logic              en,
    output logic              busy,
    output logic              done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 2);
    localparam int FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [FW-1:0] FLUSH_END = FW'(FLUSH - 1);

    state_t                         r_state;
    logic [AW-1:0]                  r_wr_ptr;
    logic [CW-1:0]                  r_rows;
    logic [CW-1:0]                  r_t;
    logic [FW-1:0]                  r_fcnt;
    logic [LANES-1:0][DATA_W-1:0]   r_lane;
    logic                           r_en;
    logic                           r_done;

    logic                           w_hs;
    logic                           w_we;
    logic                           w_take;
    logic [CW-1:0]                  w_t_next;
    logic [CW-1:0]                  w_rows_next;
    logic [CW-1:0]                  w_idx [LANES];
    logic [LANES-1:0]               w_ok;
    logic [LANES-1:0][AW-1:0]       w_raddr;
    logic [LANES-1:0][DATA_W-1:0]   w_rdata;
    logic [LANES-1:0][DATA_W-1:0]   w_lane_next;

    assign s_ready = (r_state == ST_IDLE);
    assign w_hs    = s_valid && s_ready;
    assign w_we    = w_hs && !rst;
    assign w_take  = w_hs && (s_last || r_wr_ptr == LAST_PTR);

    act_row_buf #(.DEPTH(DEPTH), .AW(AW)) u_row_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (s_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Lane k shows row (t-k): the skew comes from read indices, not delay lines.
    always_comb begin
        w_t_next    = (r_state == ST_STREAM) ? r_t + CW'(1) : '0;
        w_rows_next = (r_state == ST_STREAM) ? r_rows : CW'(r_wr_ptr) + CW'(1);
        for (int k = 0; k < LANES; k++) begin
            w_idx[k]   = w_t_next - CW'(k);
            w_ok[k]    = (w_t_next >= CW'(k)) && (w_idx[k] < w_rows_next);
            w_raddr[k] = w_ok[k] ? AW'(w_idx[k]) : '0;
        end
    end

    // A single-row tile needs its row on the same edge that writes it.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            if (!w_ok[k]) begin
                w_lane_next[k] = '0;
            end else if (w_we && w_raddr[k] == r_wr_ptr) begin
                w_lane_next[k] = s_data[k*DATA_W +: DATA_W];
            end else begin
                w_lane_next[k] = w_rdata[k];
            end
        end
    end

    // NOTE: all state and registered outputs update with non-blocking
    // assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rows   <= '0;
            r_t      <= '0;
            r_fcnt   <= '0;
            r_lane   <= '0;
            r_en     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_STREAM;
                        r_rows  <= w_rows_next;
                        r_t     <= '0;
                        r_lane  <= w_lane_next;
                        r_en    <= 1'b1;
                    end else if (w_hs) begin
                        r_wr_ptr <= r_wr_ptr + AW'(1);
                    end
                end
                ST_STREAM: begin
                    if (r_t == r_rows + CW'(1)) begin
                        r_state <= ST_FLUSH;
                        r_fcnt  <= '0;
                        r_lane  <= '0;
                    end else begin
                        r_t    <= w_t_next;
                        r_lane <= w_lane_next;
                    end
                end
                ST_FLUSH: begin
                    if (r_fcnt == FLUSH_END) begin
                        r_state <= ST_DONE;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt + FW'(1);
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_done   <= 1'b0;
                    r_wr_ptr <= '0;
                    r_t      <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in1  = r_lane[0];
    assign in2  = r_lane[1];
    assign in3  = r_lane[2];
    assign en   = r_en;
    assign done = r_done;
    assign busy = (r_state == ST_STREAM) || (r_state == ST_FLUSH);

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: directed tables, corner sequences,
// and random traffic compared each cycle against a tile-schedule model.
module tb_act_skew_feeder;

    localparam int DEPTH = 8;
    localparam int FLUSH = 3;

    typedef struct {
        logic       en;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       done;
        logic       busy;
        logic       ready;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [23:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [7:0]  in1, in2, in3;
    logic        en, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;
    int en_run   = 0;
    int last_run = 0;

    always #5 clk = ~clk;

    act_skew_feeder #(.DEPTH(DEPTH), .FLUSH(FLUSH)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .in1     (in1),
        .in2     (in2),
        .in3     (in3),
        .en      (en),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic d, input logic bz,
                                input logic r);
        vec_t v;
        v.en = e; v.a = a; v.b = b; v.c = c; v.done = d; v.busy = bz; v.ready = r;
        return v;
    endfunction

    // ---------------- reference model: per-tile output schedule ----------------
    vec_t        cur = '{en: 1'b0, a: 8'h00, b: 8'h00, c: 8'h00, done: 1'b0, busy: 1'b0, ready: 1'b1};
    vec_t        sched[$];
    logic [23:0] rows[$];

    task automatic build_tile();
        int n = rows.size();
        for (int t = 0; t < n + 2; t++) begin
            logic [7:0] lv [3];
            for (int k = 0; k < 3; k++) begin
                int i = t - k;
                lv[k] = (i >= 0 && i < n) ? rows[i][8*k +: 8] : 8'h00;
            end
            sched.push_back(mk(1'b1, lv[0], lv[1], lv[2], 1'b0, 1'b1, 1'b0));
        end
        for (int f = 0; f < FLUSH; f++) begin
            sched.push_back(mk(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0));
        end
        sched.push_back(mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
    endtask

    always @(posedge clk) begin
        if (rst) begin
            sched.delete();
            rows.delete();
            cur = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        end else begin
            if (s_valid && cur.ready) begin
                rows.push_back(s_data);
                if (s_last || rows.size() == DEPTH) begin
                    build_tile();
                    rows.delete();
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = mk(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_ready", 32'(s_ready), 32'(cur.ready));
            check("mon_en",    32'(en),      32'(cur.en));
            check("mon_in1",   32'(in1),     32'(cur.a));
            check("mon_in2",   32'(in2),     32'(cur.b));
            check("mon_in3",   32'(in3),     32'(cur.c));
            check("mon_done",  32'(done),    32'(cur.done));
            check("mon_busy",  32'(busy),    32'(cur.busy));
        end
        if (en) en_run++;
        else begin
            if (en_run != 0) last_run = en_run;
            en_run = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [23:0] d, input logic l, input logic keep, output int w);
        w = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: s_ready stayed low for %0d cycles", w);
        end
        @(posedge clk);
        #1;
        if (!keep) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!s_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: s_ready stayed low for %0d cycles", w);
        end
    endtask

    task automatic run_table(input string name, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            @(negedge clk);
            check({name, "_en"},    32'(en),      32'(tbl[i].en));
            check({name, "_in1"},   32'(in1),     32'(tbl[i].a));
            check({name, "_in2"},   32'(in2),     32'(tbl[i].b));
            check({name, "_in3"},   32'(in3),     32'(tbl[i].c));
            check({name, "_done"},  32'(done),    32'(tbl[i].done));
            check({name, "_busy"},  32'(busy),    32'(tbl[i].busy));
            check({name, "_ready"}, 32'(s_ready), 32'(tbl[i].ready));
        end
    endtask

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        vec_t q30[$];
        vec_t q31[$];
        int   w;

        // Expected tables for the two reference tiles.
        q30.push_back(mk(1, 8'h01, 8'h00, 8'h00, 0, 1, 0));
        q30.push_back(mk(1, 8'h04, 8'h02, 8'h00, 0, 1, 0));
        q30.push_back(mk(1, 8'h07, 8'h05, 8'h03, 0, 1, 0));
        q30.push_back(mk(1, 8'h00, 8'h08, 8'h06, 0, 1, 0));
        q30.push_back(mk(1, 8'h00, 8'h00, 8'h09, 0, 1, 0));
        for (int i = 0; i < 3; i++) q30.push_back(mk(1, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        q30.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        q30.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1));

        q31.push_back(mk(1, 8'hAA, 8'h00, 8'h00, 0, 1, 0));
        q31.push_back(mk(1, 8'h00, 8'hBB, 8'h00, 0, 1, 0));
        q31.push_back(mk(1, 8'h00, 8'h00, 8'hCC, 0, 1, 0));
        for (int i = 0; i < 3; i++) q31.push_back(mk(1, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        q31.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0));
        q31.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 1));

        @(posedge clk);
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_ready", 32'(s_ready), 32'(1));
        check("rst_en",    32'(en),      32'(0));
        check("rst_busy",  32'(busy),    32'(0));
        check("rst_done",  32'(done),    32'(0));
        check("rst_lanes", 32'({in1, in2, in3}), 32'(0));

        // Three-row tile.
        send(24'h030201, 1'b0, 1'b0, w);
        send(24'h060504, 1'b0, 1'b0, w);
        send(24'h090807, 1'b1, 1'b0, w);
        run_table("req030", q30);
        check("req030_en_len", 32'(last_run), 32'(8));

        // Single-row tile.
        send(24'hCCBBAA, 1'b1, 1'b0, w);
        run_table("req031", q31);
        check("req031_en_len", 32'(last_run), 32'(6));

        // Full buffer without s_last; the next beat is held until ready returns.
        for (int b = 0; b < DEPTH; b++) send(24'($urandom), 1'b0, 1'b0, w);
        send(24'h5A5A5A, 1'b1, 1'b0, w);
        check("req032_hold_wait", 32'(w), 32'(DEPTH + 2 + FLUSH + 2));
        check("req032_en_len", 32'(last_run), 32'(DEPTH + 2 + FLUSH));
        wait_idle();

        // Back-to-back tiles with s_valid held high and data changing meanwhile.
        send(24'h112233, 1'b0, 1'b1, w);
        send(24'h445566, 1'b0, 1'b1, w);
        send(24'h778899, 1'b1, 1'b1, w);
        send(24'hABCDEF, 1'b0, 1'b1, w);
        check("req035_gap", 32'(w), 32'(3 + 2 + FLUSH + 2));
        send(24'h13579B, 1'b1, 1'b0, w);
        wait_idle();

        // Reset in the middle of STREAM.
        for (int b = 0; b < 3; b++) send(24'($urandom), 1'b0, 1'b0, w);
        send(24'($urandom), 1'b1, 1'b0, w);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("req034_en",    32'(en),   32'(0));
        check("req034_busy",  32'(busy), 32'(0));
        check("req034_done",  32'(done), 32'(0));
        check("req034_lanes", 32'({in1, in2, in3}), 32'(0));
        check("req034_ready", 32'(s_ready), 32'(1));
        send(24'hF0E0D0, 1'b0, 1'b0, w);
        send(24'h0C0B0A, 1'b1, 1'b0, w);
        wait_idle();

        // Random traffic including occasional resets.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            s_valid = 1'($urandom_range(0, 1));
            s_data  = 24'($urandom);
            s_last  = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 99) == 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        repeat (30) @(posedge clk);

        @(negedge clk);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter DEPTH, default 8, maximum activation rows buffered per tile (2..16).
REQ-002 Parameter FLUSH, default 3, trailing zero cycles with en high for array drain.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  activation row beat valid.
REQ-006 s_ready  output  1  feeder can accept a beat.
REQ-007 s_data  input  24  row: [7:0] lane0, [15:8] lane1, [23:16] lane2, unsigned bytes.
REQ-008 s_last  input  1  final row of tile.
REQ-009 in1, in2, in3  output  8 each  skewed left-edge inputs, lane0..lane2, to the 3x3 PE array.
REQ-010 en  output  1  array enable.
REQ-011 busy  output  1  high in STREAM or FLUSH.
REQ-012 done  output  1  one-cycle pulse at tile completion.

Function
REQ-013 FSM states: IDLE, STREAM, FLUSH, DONE.
REQ-014 IDLE: s_ready=1, en=0; each handshake (s_valid and s_ready) writes s_data to buffer[wr_ptr], wr_ptr increments.
REQ-015 IDLE->STREAM on handshake with s_last=1 or with wr_ptr=DEPTH-1; row count N = wr_ptr+1 latched.
REQ-016 Beats with s_valid low are ignored; s_last without s_valid has no effect.
REQ-017 s_ready SHALL be 0 in STREAM, FLUSH and DONE.
REQ-018 STREAM lasts exactly N+2 cycles, index t=0..N+1; lane k output = byte k of row t-k when 0<=t-k<N, else 0x00.
REQ-019 FLUSH lasts exactly FLUSH cycles, all lanes 0x00, en=1.
REQ-020 in1/in2/in3 and en are registered: values for STREAM cycle t appear in the cycle following t's entry edge; en is high for exactly N+2+FLUSH consecutive cycles starting the cycle after the last-beat handshake.
REQ-021 DONE lasts one cycle: done=1, en=0, lanes 0x00; then IDLE with wr_ptr=0.
REQ-022 N=1 is legal (3+FLUSH enable cycles); N=DEPTH forces STREAM without s_last (wrap-free, wr_ptr never exceeds DEPTH-1).
REQ-023 Buffer contents are not cleared between tiles; only rows 0..N-1 of the current tile are ever emitted.
REQ-024 busy = state in {STREAM, FLUSH}.

Reset
REQ-025 rst, at any time including mid-STREAM, SHALL force state IDLE, wr_ptr=0, N=0, t=0, in1=in2=in3=0, en=0, done=0, busy=0; s_ready=1 the cycle after rst deasserts.
REQ-026 Buffer storage needs no reset.

Structure
REQ-027 Shared package holds lane count (3), data width (8), row width (24) and FSM state encoding.
REQ-028 One sub-module, act_row_buf: DEPTH x 24 register file, one write port, three combinational read ports (one per lane).
REQ-029 Skew SHALL be produced by per-lane read index t-k, not by delay-line registers.

Verification
REQ-030 Rows 0x030201, 0x060504, 0x090807 (last on third) -> en high 8 cycles; in1 = 01,04,07,00x5; in2 = 00,02,05,08,00x4; in3 = 00,00,03,06,09,00x3; done pulse next cycle.
REQ-031 Single row 0xCCBBAA with s_last -> en 6 cycles; in1 = AA,00..; in2 = 00,BB,00..; in3 = 00,00,CC,00..
REQ-032 8 rows without s_last (DEPTH=8) -> s_ready drops after 8th handshake, en high 13 cycles, 9th beat held until s_ready returns.
REQ-033 s_valid held high with s_ready low during STREAM -> no buffer write, s_data change ignored, output sequence unchanged.
REQ-034 rst asserted at STREAM cycle t=2 -> next cycle en=0, lanes 0, busy=0, no done; fresh 2-row tile then streams correctly.
REQ-035 Back-to-back tiles with s_valid constantly high -> second tile's first beat accepted the cycle after done, output matches REQ-018.
